// File: rtl/pau_wb_buffer.sv
// Result writeback FIFO between the PAU and the core writeback port.
// Optional same-cycle bypass of an empty buffer is enabled by defining PAU_WB_BYPASS_EN.
module pau_wb_buffer #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  input  logic [WIDTH-1:0]           res_data_i,
  input  logic [TRANS_ID_BITS-1:0]   res_trans_id_i,
  // opcode space runs up to PMV_X2P=22, which needs a 5-bit field
  input  logic [4:0]                 res_op_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [WIDTH-1:0]           wb_data_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic                       wb_is_int_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]         data_mem_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem_q   [DEPTH];
  logic                     int_mem_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic res_is_int;
  logic push, pop, do_push, do_pop, byp_take;

  always_comb begin
    res_is_int = 1'b0;
    case (res_op_i)
      5'd10, 5'd11, 5'd12, 5'd13, 5'd21: res_is_int = 1'b1;
      default:                           res_is_int = 1'b0;
    endcase
  end

  always_comb begin
    res_ready_o = (count_q != FULL_CNT);
    count_o     = count_q;
`ifdef PAU_WB_BYPASS_EN
    // An empty buffer forwards the incoming result; if taken, it never enters storage
    if ((count_q == '0) && res_valid_i && !flush_i) begin
      wb_valid_o    = 1'b1;
      wb_data_o     = res_data_i;
      wb_trans_id_o = res_trans_id_i;
      wb_is_int_o   = res_is_int;
      byp_take      = wb_ready_i;
    end else begin
      wb_valid_o    = (count_q != '0);
      wb_data_o     = data_mem_q[rd_ptr_q];
      wb_trans_id_o = id_mem_q[rd_ptr_q];
      wb_is_int_o   = int_mem_q[rd_ptr_q];
      byp_take      = 1'b0;
    end
`else
    wb_valid_o    = (count_q != '0);
    wb_data_o     = data_mem_q[rd_ptr_q];
    wb_trans_id_o = id_mem_q[rd_ptr_q];
    wb_is_int_o   = int_mem_q[rd_ptr_q];
    byp_take      = 1'b0;
`endif
  end

  always_comb begin
    push     = res_valid_i && res_ready_o;
    pop      = wb_valid_o && wb_ready_i;
    do_push  = push && !byp_take && !flush_i;
    do_pop   = pop && !byp_take && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      data_mem_q[wr_ptr_q] <= res_data_i;
      id_mem_q[wr_ptr_q]   <= res_trans_id_i;
      int_mem_q[wr_ptr_q]  <= res_is_int;
    end
  end

endmodule

// File: tb/tb_pau_wb_buffer.sv
// Self-checking bench for pau_wb_buffer against a queue-based reference model.
module tb_pau_wb_buffer;

  localparam int W  = 64;
  localparam int D  = 4;
  localparam int TB = 3;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, res_valid_i, res_ready_o, wb_valid_o, wb_ready_i, wb_is_int_o;
  logic [W-1:0]  res_data_i, wb_data_o;
  logic [TB-1:0] res_trans_id_i, wb_trans_id_o;
  logic [4:0]    res_op_i;
  logic [2:0]    count_o;

  typedef struct {
    logic [W-1:0]  data;
    logic [TB-1:0] id;
    logic          is_int;
  } ent_t;

  ent_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pau_wb_buffer #(.WIDTH(W), .DEPTH(D), .TRANS_ID_BITS(TB)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data_i(res_data_i),
    .res_trans_id_i(res_trans_id_i), .res_op_i(res_op_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_trans_id_o(wb_trans_id_o), .wb_is_int_o(wb_is_int_o), .count_o(count_o)
  );

  function automatic logic op_is_int(input logic [4:0] op);
    return op inside {5'd10, 5'd11, 5'd12, 5'd13, 5'd21};
  endfunction

  function automatic logic bypass_now();
`ifdef PAU_WB_BYPASS_EN
    return (q.size() == 0) && res_valid_i && !flush_i;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_valid();
    return (q.size() != 0) || bypass_now();
  endfunction

  function automatic ent_t exp_head();
    ent_t e;
    if (bypass_now()) begin
      e.data = res_data_i; e.id = res_trans_id_i; e.is_int = op_is_int(res_op_i);
    end else e = q[0];
    return e;
  endfunction

  task automatic drive(input logic rv, input logic [W-1:0] data, input logic [TB-1:0] id,
                       input logic [4:0] op, input logic wr, input logic fl);
    res_valid_i = rv; res_data_i = data; res_trans_id_i = id; res_op_i = op;
    wb_ready_i = wr; flush_i = fl;
    #1;
  endtask

  // Advance the model by one clock using the currently driven inputs, then the DUT.
  task automatic step();
    logic push, pop, byp;
    ent_t e;
    byp  = bypass_now();
    push = res_valid_i && (q.size() != D);
    pop  = exp_valid() && wb_ready_i;
    if (flush_i) q.delete();
    else if (!(byp && wb_ready_i)) begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.data = res_data_i; e.id = res_trans_id_i; e.is_int = op_is_int(res_op_i);
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flush();
    drive(1'b0, '0, '0, 5'd0, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b0, '0, '0, 5'd0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d exp 0", count_o); end
    vectors++; if (wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid: got %b exp 0", wb_valid_o); end
    vectors++; if (res_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_res_ready: got %b exp 1", res_ready_o); end
    rst_i = 1'b0;
    q.delete();
    @(negedge clk);
  endtask

  task automatic test_single();
    do_flush();
    drive(1'b1, 64'h4000, 3'd5, 5'd2, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 5'd0, 1'b1, 1'b0);
`ifndef PAU_WB_BYPASS_EN
    vectors++; if (wb_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b exp 1", wb_valid_o); end
    vectors++; if (wb_data_o !== 64'h4000) begin miscompares++; $display("FAIL single_data: got %h exp 4000", wb_data_o); end
    vectors++; if (wb_trans_id_o !== 3'd5) begin miscompares++; $display("FAIL single_id: got %0d exp 5", wb_trans_id_o); end
    vectors++; if (wb_is_int_o !== 1'b0) begin miscompares++; $display("FAIL single_is_int: got %b exp 0", wb_is_int_o); end
`endif
    step();
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL single_count: got %0d exp 0", count_o); end
  endtask

  task automatic test_full();
    do_flush();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(i * 3 + 1), 3'(i), 5'd0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 64'hdead, 3'd7, 5'd0, 1'b0, 1'b0);
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d exp 4", count_o); end
    vectors++; if (res_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b exp 0", res_ready_o); end
    step();
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL full_5th_count: got %0d exp 4", count_o); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 5'd0, 1'b1, 1'b0);
      vectors++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'(i)) begin
        miscompares++; $display("FAIL full_drain_id: got v=%b id=%0d exp v=1 id=%0d", wb_valid_o, wb_trans_id_o, i);
      end
      step();
    end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL full_drained: got %0d exp 0", count_o); end
  endtask

  task automatic test_wrap();
    do_flush();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'(i), 3'(i), 5'd1, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 64'(i + 2), 3'(i + 2), 5'd1, 1'b1, 1'b0);
      vectors++; if (count_o !== 3'd2) begin miscompares++; $display("FAIL wrap_count: got %0d exp 2", count_o); end
      vectors++; if (wb_trans_id_o !== 3'(i)) begin miscompares++; $display("FAIL wrap_id: got %0d exp %0d", wb_trans_id_o, i); end
      step();
    end
    vectors++; if (count_o !== 3'd2) begin miscompares++; $display("FAIL wrap_end_count: got %0d exp 2", count_o); end
  endtask

  task automatic test_is_int();
    logic [4:0] ops [3];
    logic       exp [3];
    ops[0] = 5'd11; ops[1] = 5'd21; ops[2] = 5'd22;
    exp[0] = 1'b1;  exp[1] = 1'b1;  exp[2] = 1'b0;
    do_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(i), 3'(i), ops[i], 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 5'd0, 1'b1, 1'b0);
      vectors++; if (wb_is_int_o !== exp[i]) begin
        miscompares++; $display("FAIL is_int_op%0d: got %b exp %b", ops[i], wb_is_int_o, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_flush_reset();
    do_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(i), 3'(i), 5'd3, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 64'h99, 3'd6, 5'd3, 1'b1, 1'b1);
    vectors++; if (res_ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b exp 1", res_ready_o); end
    step();
    drive(1'b0, '0, '0, 5'd0, 1'b0, 1'b0);
    vectors++; if (count_o !== 3'd0 || wb_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_clear: got count=%0d v=%b exp count=0 v=0", count_o, wb_valid_o);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'(i), 3'(i), 5'd3, 1'b0, 1'b0);
      step();
    end
    rst_i = 1'b1;
    #1;
    vectors++; if (count_o !== 3'd0 || wb_valid_o !== 1'b0 || res_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL async_reset: got count=%0d v=%b rdy=%b exp 0 0 1", count_o, wb_valid_o, res_ready_o);
    end
    q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    drive(1'b1, 64'h1234, 3'd4, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 5'd0, 1'b0, 1'b0);
    vectors++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd4 || wb_data_o !== 64'h1234) begin
      miscompares++; $display("FAIL post_reset_head: got v=%b id=%0d d=%h exp 1 4 1234", wb_valid_o, wb_trans_id_o, wb_data_o);
    end
  endtask

`ifdef PAU_WB_BYPASS_EN
  task automatic test_bypass();
    do_flush();
    drive(1'b1, 64'h77, 3'd3, 5'd10, 1'b1, 1'b0);
    vectors++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd3 || wb_is_int_o !== 1'b1) begin
      miscompares++; $display("FAIL bypass_same_cycle: got v=%b id=%0d int=%b exp 1 3 1", wb_valid_o, wb_trans_id_o, wb_is_int_o);
    end
    step();
    drive(1'b0, '0, '0, 5'd0, 1'b0, 1'b0);
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL bypass_count: got %0d exp 0", count_o); end
  endtask
`endif

  task automatic test_random();
    ent_t h;
    do_flush();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 3'($urandom), 5'($urandom_range(0, 31)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      vectors++; if (count_o !== 3'(q.size())) begin miscompares++; $display("FAIL rand_count: got %0d exp %0d", count_o, q.size()); end
      vectors++; if (res_ready_o !== (q.size() != D)) begin miscompares++; $display("FAIL rand_ready: got %b exp %b", res_ready_o, q.size() != D); end
      vectors++; if (wb_valid_o !== exp_valid()) begin miscompares++; $display("FAIL rand_valid: got %b exp %b", wb_valid_o, exp_valid()); end
      if (exp_valid()) begin
        h = exp_head();
        vectors++; if (wb_data_o !== h.data || wb_trans_id_o !== h.id || wb_is_int_o !== h.is_int) begin
          miscompares++;
          $display("FAIL rand_head: got d=%h id=%0d int=%b exp d=%h id=%0d int=%b",
                   wb_data_o, wb_trans_id_o, wb_is_int_o, h.data, h.id, h.is_int);
        end
      end
      step();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, '0, '0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_is_int();
    test_flush_reset();
`ifdef PAU_WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
